cycle_profile_sequencer: RTL and testbench
==========================================

Name: cycle_profile_sequencer

Overview:
- Sequences one backend cycle controller through a programmable list of drive profiles.
- Holds a shadow bank of configuration profiles written by the host. Each profile is 10 x 16-bit words, mapping to config addresses 0x00-0x09.
- On start, it serially loads a profile over the config write bus, enables the timer, and counts completed update cycles. It then advances to the next profile, loops, or finishes.

Parameters:
- NUM_PROFILES, 4, number of shadow profiles; must be a power of two.
- PROFILE_BITS, 2, log2(NUM_PROFILES).
- REPEAT_WIDTH, 8, width of the per-profile update-cycle repeat counter.
- WDOG_WIDTH, 24, width of the watchdog counter (optional feature only).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- host_we  in  1  shadow bank write strobe
- host_profile  in  PROFILE_BITS  profile index for host write
- host_word  in  4  word index 0-9; values 10-15 are ignored
- host_wdata  in  16  write data
- host_err  out  1  one-cycle pulse: host write was blocked
- start  in  1  single-cycle start request
- abort  in  1  single-cycle abort request
- profile_first  in  PROFILE_BITS  first profile of the sequence
- profile_last  in  PROFILE_BITS  last profile of the sequence
- repeat_count  in  REPEAT_WIDTH  update cycles per profile; 0 is treated as 1
- loop_en  in  1  after profile_last, wrap to profile_first instead of finishing
- update_cycle_complete  in  1  completion status from the cycle controller
- write_config_n  out  1  active-low config write strobe
- config_address  out  6  config address
- config_data  out  16  config data
- timer_enable  out  1  cycle controller timer enable
- busy  out  1  high in any state other than IDLE
- active_profile  out  PROFILE_BITS  profile currently loaded or running
- done  out  1  one-cycle pulse when the sequence finishes normally
- wdog_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values: all outputs registered.
  - write_config_n=1; timer_enable=0.
  - config_address=0, config_data=0, active_profile=0.
  - busy, done, host_err, wdog_timeout all 0.
  - State IDLE. Shadow bank reset to 0.
- Shadow bank writes:
  - A host_we with host_word<=9 writes the addressed word the next edge.
  - Exception: if busy and host_profile==active_profile, the write is dropped and host_err pulses the following cycle.
- States: IDLE, LOAD, SETTLE, RUN, GAP, DONE.
- IDLE:
  - start: latch profile_first, profile_last, repeat_count and loop_en; active_profile=profile_first; word_idx=0; rep_cnt=0; go to LOAD.
- LOAD:
  - One word per cycle: write_config_n=0, config_address=word_idx, config_data=bank[active_profile][word_idx].
  - Exactly 10 consecutive write cycles, addresses 0..9 in order, then SETTLE.
  - timer_enable=0 throughout.
- SETTLE:
  - One cycle with write_config_n=1, timer_enable=0; go to RUN with blank_cnt=2.
- RUN:
  - timer_enable=1.
  - update_cycle_complete is ignored while blank_cnt!=0; blank_cnt decrements each cycle. This covers the stale status from the previous profile.
  - After blanking, update_cycle_complete=1 counts one update cycle, then:
    - rep_cnt+1 < max(repeat_count,1): rep_cnt++ and go to GAP.
    - Otherwise, active_profile!=profile_last: active_profile+1 (mod NUM_PROFILES), rep_cnt=0, word_idx=0, go to LOAD.
    - Otherwise, loop_en=1: active_profile=profile_first and LOAD.
    - Otherwise: DONE.
- GAP:
  - One cycle with timer_enable=0; this restarts the controller's timers. Then RUN with blank_cnt=2.
- DONE:
  - done=1 for one cycle; go to IDLE.
- Sequence order:
  - When profile_first > profile_last, the sequence wraps through NUM_PROFILES-1 to 0.
  - When profile_first==profile_last, only that profile runs.
- abort:
  - Has priority in any state. Next cycle: IDLE, timer_enable=0, write_config_n=1, no done pulse.
  - An abort in the same cycle as start wins.
- start while busy is ignored.
- Reset mid-operation forces all outputs to their reset values immediately (asynchronous).

Optional Feature:
- Macro: CYCLE_WATCHDOG_EN.
- When defined:
  - A WDOG_WIDTH-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches all-ones before a counted completion, the block behaves as abort and pulses wdog_timeout.
- When undefined:
  - No counter is built; wdog_timeout is tied 0.

Test Plan:
- Load profile 1 with words 0x0001..0x000A; start with first=last=1, repeat=1, update_cycle_complete held 0 → 10 cycles of write_config_n=0 at addresses 0..9 with data 0x0001..0x000A, one SETTLE cycle, then timer_enable=1. Pulse complete 5 cycles later → done pulses once, busy falls.
- first=0, last=2, repeat=3, complete pulsed each RUN window → profiles loaded in order 0,1,2; three RUN windows each separated by single-cycle GAP timer_enable=0; done after the ninth completion.
- update_cycle_complete held 1 → it is not counted during the first 2 RUN cycles of each window; repeat=2 finishes after exactly 2 counted completions.
- loop_en=1, first=3, last=0 with NUM_PROFILES=4 → order 3,0,3,0…; abort mid-LOAD → timer_enable=0, write_config_n=1 next cycle, no done.
- Host write to active profile during RUN → bank unchanged, host_err pulses one cycle; write to an inactive profile succeeds.
- CYCLE_WATCHDOG_EN with WDOG_WIDTH=4 and no completion → wdog_timeout pulses after 15 RUN cycles, block returns to IDLE.

Source files
------------

// File: rtl/cycle_profile_sequencer.sv
// Sequences a backend cycle controller through host-written shadow drive profiles.
// Define CYCLE_WATCHDOG_EN to build the RUN-phase watchdog; otherwise wdog_timeout stays 0.
module cycle_profile_sequencer #(
  parameter int NUM_PROFILES = 4,
  parameter int PROFILE_BITS = 2,
  parameter int REPEAT_WIDTH = 8,
  parameter int WDOG_WIDTH   = 24
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    host_we,
  input  logic [PROFILE_BITS-1:0] host_profile,
  input  logic [3:0]              host_word,
  input  logic [15:0]             host_wdata,
  output logic                    host_err,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PROFILE_BITS-1:0] profile_first,
  input  logic [PROFILE_BITS-1:0] profile_last,
  input  logic [REPEAT_WIDTH-1:0] repeat_count,
  input  logic                    loop_en,
  input  logic                    update_cycle_complete,
  output logic                    write_config_n,
  output logic [5:0]              config_address,
  output logic [15:0]             config_data,
  output logic                    timer_enable,
  output logic                    busy,
  output logic [PROFILE_BITS-1:0] active_profile,
  output logic                    done,
  output logic                    wdog_timeout
);

  localparam int NUM_WORDS = 10;

  if ((NUM_PROFILES != (1 << PROFILE_BITS)) || (WDOG_WIDTH < 2)) begin : g_bad_params
    $error("cycle_profile_sequencer: NUM_PROFILES must equal 2**PROFILE_BITS and WDOG_WIDTH >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t                  state;
  logic [15:0]             bank [NUM_PROFILES][NUM_WORDS];
  logic [3:0]              word_idx;
  logic [3:0]              word_next;
  logic [1:0]              blank_cnt;
  logic [REPEAT_WIDTH-1:0] rep_cnt;
  logic [REPEAT_WIDTH-1:0] rep_lat;
  logic [REPEAT_WIDTH-1:0] rep_target;
  logic [REPEAT_WIDTH-1:0] rep_next;
  logic [PROFILE_BITS-1:0] first_lat;
  logic [PROFILE_BITS-1:0] last_lat;
  logic [PROFILE_BITS-1:0] reload_profile;
  logic                    loop_lat;
  logic                    host_hit;
  logic                    host_blocked;
  logic                    counted;
  logic                    wdog_expire;

  assign host_hit     = host_we && (host_word <= 4'd9);
  assign host_blocked = busy && (host_profile == active_profile);
  assign word_next    = word_idx + 4'd1;
  assign rep_target   = (rep_lat == '0) ? REPEAT_WIDTH'(1) : rep_lat;
  assign rep_next     = rep_cnt + REPEAT_WIDTH'(1);
  assign counted      = (state == S_RUN) && (blank_cnt == 2'd0) && update_cycle_complete;
  // After the last profile either advance or wrap to the first; modulo wrap is free for power-of-two counts.
  assign reload_profile = (active_profile != last_lat) ? active_profile + PROFILE_BITS'(1) : first_lat;

`ifdef CYCLE_WATCHDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_cnt;

  assign wdog_expire = (state == S_RUN) && !counted && (wdog_cnt == ~WDOG_WIDTH'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
    end else if (state != S_RUN) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + WDOG_WIDTH'(1);
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // Shadow bank: the profile being driven is frozen while the sequencer is busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PROFILES; p++) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          bank[p][w] <= '0;
        end
      end
      host_err <= 1'b0;
    end else begin
      host_err <= host_hit && host_blocked;
      if (host_hit && !host_blocked) begin
        bank[host_profile][host_word] <= host_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      word_idx       <= '0;
      blank_cnt      <= '0;
      rep_cnt        <= '0;
      rep_lat        <= '0;
      first_lat      <= '0;
      last_lat       <= '0;
      loop_lat       <= 1'b0;
      write_config_n <= 1'b1;
      config_address <= '0;
      config_data    <= '0;
      timer_enable   <= 1'b0;
      busy           <= 1'b0;
      active_profile <= '0;
      done           <= 1'b0;
      wdog_timeout   <= 1'b0;
    end else begin
      done         <= 1'b0;
      wdog_timeout <= 1'b0;
      if (abort || wdog_expire) begin
        state          <= S_IDLE;
        busy           <= 1'b0;
        timer_enable   <= 1'b0;
        write_config_n <= 1'b1;
        wdog_timeout   <= !abort;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              first_lat      <= profile_first;
              last_lat       <= profile_last;
              rep_lat        <= repeat_count;
              loop_lat       <= loop_en;
              active_profile <= profile_first;
              rep_cnt        <= '0;
              word_idx       <= '0;
              write_config_n <= 1'b0;
              config_address <= '0;
              config_data    <= bank[profile_first][0];
              busy           <= 1'b1;
              state          <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (word_idx == 4'd9) begin
              write_config_n <= 1'b1;
              state          <= S_SETTLE;
            end else begin
              word_idx       <= word_next;
              config_address <= {2'b00, word_next};
              config_data    <= bank[active_profile][word_next];
            end
          end
          S_SETTLE, S_GAP: begin
            timer_enable <= 1'b1;
            blank_cnt    <= 2'd2;
            state        <= S_RUN;
          end
          S_RUN: begin
            // The first two RUN cycles may still see the previous window's completion.
            if (blank_cnt != 2'd0) begin
              blank_cnt <= blank_cnt - 2'd1;
            end else if (update_cycle_complete) begin
              timer_enable <= 1'b0;
              if (rep_next < rep_target) begin
                rep_cnt <= rep_next;
                state   <= S_GAP;
              end else if ((active_profile != last_lat) || loop_lat) begin
                active_profile <= reload_profile;
                rep_cnt        <= '0;
                word_idx       <= '0;
                write_config_n <= 1'b0;
                config_address <= '0;
                config_data    <= bank[reload_profile][0];
                state          <= S_LOAD;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cycle_profile_sequencer.sv
// Randomized plus directed bench for cycle_profile_sequencer against a phase-queue reference model.
module tb_cycle_profile_sequencer;
  localparam int NP = 4;
  localparam int PB = 2;
  localparam int RW = 8;
  localparam int WW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          host_we = 1'b0;
  logic [PB-1:0] host_profile = '0;
  logic [3:0]    host_word = '0;
  logic [15:0]   host_wdata = '0;
  logic          host_err;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PB-1:0] profile_first = '0;
  logic [PB-1:0] profile_last = '0;
  logic [RW-1:0] repeat_count = '0;
  logic          loop_en = 1'b0;
  logic          update_cycle_complete = 1'b0;
  logic          write_config_n;
  logic [5:0]    config_address;
  logic [15:0]   config_data;
  logic          timer_enable;
  logic          busy;
  logic [PB-1:0] active_profile;
  logic          done;
  logic          wdog_timeout;

  always #5 clock = ~clock;

  cycle_profile_sequencer #(
    .NUM_PROFILES(NP), .PROFILE_BITS(PB), .REPEAT_WIDTH(RW), .WDOG_WIDTH(WW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .host_we(host_we), .host_profile(host_profile),
    .host_word(host_word), .host_wdata(host_wdata), .host_err(host_err), .start(start),
    .abort(abort), .profile_first(profile_first), .profile_last(profile_last),
    .repeat_count(repeat_count), .loop_en(loop_en), .update_cycle_complete(update_cycle_complete),
    .write_config_n(write_config_n), .config_address(config_address), .config_data(config_data),
    .timer_enable(timer_enable), .busy(busy), .active_profile(active_profile), .done(done),
    .wdog_timeout(wdog_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the sequence is a queue of output phases; RUN windows last until a counted completion.
  localparam int K_IDLE = 0, K_WORD = 1, K_SETTLE = 2, K_RUN = 3, K_GAP = 4, K_DONE = 5;
  typedef struct { int kind; int word; } ent_t;

  ent_t        m_cur;
  ent_t        m_q[$];
  logic [15:0] m_bank [NP][10];
  int          m_age, m_act, m_cnt, m_first, m_last, m_rep, m_loop;
  logic        e_err, e_wdog;

  logic          s_we, s_start, s_abort, s_loop, s_cmp;
  logic [PB-1:0] s_prof, s_first, s_last;
  logic [3:0]    s_word;
  logic [15:0]   s_data;
  logic [RW-1:0] s_rep;

  function automatic ent_t ent(input int k, input int w);
    ent_t e;
    e.kind = k;
    e.word = w;
    return e;
  endfunction

  function automatic void push_profile();
    for (int w = 0; w < 10; w++) m_q.push_back(ent(K_WORD, w));
    m_q.push_back(ent(K_SETTLE, 0));
    m_q.push_back(ent(K_RUN, 0));
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NP; p++)
      for (int w = 0; w < 10; w++) m_bank[p][w] = '0;
    m_q.delete();
    m_cur = ent(K_IDLE, 0);
    m_act = 0; m_age = 0; m_cnt = 0;
    e_err = 1'b0; e_wdog = 1'b0;
  endfunction

  function automatic void model_step();
    bit prev_busy = (m_cur.kind != K_IDLE);
    bit wr_ok = s_we && (s_word <= 4'd9);
    e_err  = wr_ok && prev_busy && (int'(s_prof) == m_act);
    e_wdog = 1'b0;
    if (s_abort) begin
      m_q.delete();
      m_cur = ent(K_IDLE, 0);
    end else if (m_cur.kind == K_IDLE) begin
      if (s_start) begin
        m_first = s_first; m_last = s_last; m_rep = s_rep; m_loop = s_loop;
        m_act = s_first; m_cnt = 0;
        push_profile();
        m_cur = m_q.pop_front(); m_age = 0;
      end
    end else if (m_cur.kind == K_RUN) begin
      if (m_age >= 2 && s_cmp) begin
        m_cnt++;
        if (m_cnt < ((m_rep == 0) ? 1 : m_rep)) begin
          m_q.push_back(ent(K_GAP, 0));
          m_q.push_back(ent(K_RUN, 0));
        end else if (m_act != m_last) begin
          m_act = (m_act + 1) % NP; m_cnt = 0; push_profile();
        end else if (m_loop != 0) begin
          m_act = m_first; m_cnt = 0; push_profile();
        end else begin
          m_q.push_back(ent(K_DONE, 0));
          m_q.push_back(ent(K_IDLE, 0));
        end
        m_cur = m_q.pop_front(); m_age = 0;
      end
`ifdef CYCLE_WATCHDOG_EN
      else if (m_age == (1 << WW) - 2) begin
        m_q.delete();
        m_cur = ent(K_IDLE, 0);
        e_wdog = 1'b1;
      end
`endif
      else m_age++;
    end else begin
      m_cur = m_q.pop_front(); m_age = 0;
    end
  endfunction

  task automatic compare_outputs();
    chk("busy", busy, m_cur.kind != K_IDLE);
    chk("timer_enable", timer_enable, m_cur.kind == K_RUN);
    chk("write_config_n", write_config_n, m_cur.kind != K_WORD);
    chk("done", done, m_cur.kind == K_DONE);
    chk("host_err", host_err, e_err);
    chk("wdog_timeout", wdog_timeout, e_wdog);
    chk("active_profile", active_profile, m_act);
    if (m_cur.kind == K_WORD) begin
      chk("config_address", config_address, m_cur.word);
      chk("config_data", config_data, m_bank[m_act][m_cur.word]);
    end
  endtask

  always @(posedge clock) begin
    s_we = host_we; s_prof = host_prof_w(); s_word = host_word; s_data = host_wdata;
    s_start = start; s_abort = abort; s_first = profile_first; s_last = profile_last;
    s_rep = repeat_count; s_loop = loop_en; s_cmp = update_cycle_complete;
    #1;
    if (!reset_n) model_reset();
    else begin
      model_step();
      if (s_we && s_word <= 4'd9 && !e_err) m_bank[s_prof][s_word] = s_data;
      compare_outputs();
    end
  end

  function automatic logic [PB-1:0] host_prof_w();
    return host_profile;
  endfunction

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wcn"}, write_config_n, 1'b1);
    chk({tag, "_te"}, timer_enable, 1'b0);
    chk({tag, "_addr"}, config_address, 0);
    chk({tag, "_data"}, config_data, 0);
    chk({tag, "_act"}, active_profile, 0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, host_err, 1'b0);
    chk({tag, "_wdog"}, wdog_timeout, 1'b0);
  endtask

  task automatic host_write(input int p, input int w, input int d);
    host_we = 1'b1; host_profile = PB'(p); host_word = 4'(w); host_wdata = 16'(d);
    cyc();
    host_we = 1'b0;
  endtask

  task automatic launch(input int f, input int l, input int r, input bit lp);
    profile_first = PB'(f); profile_last = PB'(l); repeat_count = RW'(r); loop_en = lp;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int loads, dones, gaps, te_cycles, d1, d2;
    int order[$];
    bit did_reset;
    repeat (3) cyc();
    check_reset_values("reset");
    reset_n = 1'b1;
    cyc();

    // Directed 1: single profile, literal load trace and completion.
    for (int w = 0; w < 10; w++) host_write(1, w, w + 1);
    launch(1, 1, 1, 1'b0);
    for (int w = 0; w < 10; w++) begin
      chk("t1_wcn", write_config_n, 1'b0);
      chk("t1_addr", config_address, w);
      chk("t1_data", config_data, w + 1);
      cyc();
    end
    chk("t1_settle_wcn", write_config_n, 1'b1);
    chk("t1_settle_te", timer_enable, 1'b0);
    cyc();
    chk("t1_run_te", timer_enable, 1'b1);
    repeat (5) cyc();
    update_cycle_complete = 1'b1;
    cyc();
    update_cycle_complete = 1'b0;
    chk("t1_done", done, 1'b1);
    cyc();
    chk("t1_done_clear", done, 1'b0);
    chk("t1_busy_fall", busy, 1'b0);

    // Directed 2: profiles 0..2, three windows each.
    loads = 0; dones = 0; gaps = 0; order.delete();
    launch(0, 2, 3, 1'b0);
    for (int c = 0; c < 400; c++) begin
      if (!write_config_n && config_address == 0) order.push_back(int'(active_profile));
      if (!write_config_n) loads++;
      if (done) dones++;
      if (busy && !timer_enable && write_config_n && !done) gaps++;
      if (dones > 0 && !busy) break;
      update_cycle_complete = timer_enable & 1'($urandom_range(0, 1));
      cyc();
    end
    update_cycle_complete = 1'b0;
    chk("t2_order_len", order.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_order", (order.size() > i) ? order[i] : -1, i);
    chk("t2_loads", loads, 30);
    chk("t2_dones", dones, 1);
    chk("t2_settle_gap_cycles", gaps, 9);

    // Directed 3: completion held high, repeat 2.
    te_cycles = 0; dones = 0;
    update_cycle_complete = 1'b1;
    launch(0, 0, 2, 1'b0);
    for (int c = 0; c < 200; c++) begin
      if (timer_enable) te_cycles++;
      if (done) dones++;
      if (dones > 0 && !busy) break;
      cyc();
    end
    update_cycle_complete = 1'b0;
    chk("t3_te_cycles", te_cycles, 6);
    chk("t3_dones", dones, 1);

    // Directed 4: wrapping loop 3,0,3,0 then abort mid-load.
    order.delete(); dones = 0;
    launch(3, 0, 1, 1'b1);
    for (int c = 0; c < 400; c++) begin
      if (!write_config_n && config_address == 0) order.push_back(int'(active_profile));
      if (order.size() >= 5 && !write_config_n && config_address == 4) begin
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t4_abort_te", timer_enable, 1'b0);
        chk("t4_abort_wcn", write_config_n, 1'b1);
        chk("t4_abort_busy", busy, 1'b0);
        break;
      end
      update_cycle_complete = timer_enable;
      cyc();
    end
    update_cycle_complete = 1'b0;
    for (int i = 0; i < 4; i++) chk("t4_order", (order.size() > i) ? order[i] : -1, (i % 2 == 0) ? 3 : 0);
    repeat (5) begin
      if (done) dones++;
      cyc();
    end
    chk("t4_no_done", dones, 0);

    // Directed 5: host write blocking on the active profile.
    host_write(2, 3, 16'h0055);
    launch(2, 2, 1, 1'b0);
    for (int c = 0; c < 40 && !timer_enable; c++) cyc();
    chk("t5_running", timer_enable, 1'b1);
    host_write(2, 3, 16'hBEEF);
    chk("t5_err_pulse", host_err, 1'b1);
    cyc();
    chk("t5_err_clear", host_err, 1'b0);
    host_write(1, 3, 16'h1234);
    chk("t5_err_inactive", host_err, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    d1 = -1; d2 = -1; dones = 0;
    launch(1, 2, 1, 1'b0);
    for (int c = 0; c < 200; c++) begin
      if (!write_config_n && config_address == 3 && active_profile == 1) d1 = config_data;
      if (!write_config_n && config_address == 3 && active_profile == 2) d2 = config_data;
      if (done) dones++;
      if (dones > 0 && !busy) break;
      update_cycle_complete = timer_enable;
      cyc();
    end
    update_cycle_complete = 1'b0;
    chk("t5_inactive_written", d1, 16'h1234);
    chk("t5_active_unchanged", d2, 16'h0055);

`ifdef CYCLE_WATCHDOG_EN
    // Directed 6: watchdog expiry with no completion.
    te_cycles = 0; dones = 0;
    launch(0, 0, 1, 1'b0);
    for (int c = 0; c < 100; c++) begin
      if (timer_enable) te_cycles++;
      if (wdog_timeout) begin
        dones++;
        break;
      end
      cyc();
    end
    chk("t6_wdog_pulse", dones, 1);
    chk("t6_run_cycles", te_cycles, 15);
    chk("t6_idle", busy, 1'b0);
    cyc();
`endif

    // Randomized traffic with one asynchronous reset while busy.
    did_reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 1500 && !did_reset && busy) begin
        did_reset = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        cyc();
        reset_n = 1'b1;
      end
      host_we = ($urandom_range(0, 3) == 0);
      host_profile = PB'($urandom);
      host_word = 4'($urandom_range(0, 11));
      host_wdata = 16'($urandom);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 79) == 0);
      profile_first = PB'($urandom);
      profile_last = PB'($urandom);
      repeat_count = RW'($urandom_range(0, 3));
      loop_en = ($urandom_range(0, 3) == 0);
      update_cycle_complete = ($urandom_range(0, 2) == 0);
      cyc();
    end
    chk("async_reset_exercised", did_reset, 1'b1);
    host_we = 1'b0; start = 1'b0; abort = 1'b0; update_cycle_complete = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
